game_control: RTL and testbench

- Upstream control FSM for the flappy-bird datapath; generates `cur_state` and per-frame strobes.
- Sequences each frame: draw bird, draw top wall, draw bottom wall, hold one frame period, erase all three, update positions, check collision.
- Handshakes with the rectangle drawer through `finished_draw`; samples `collision` once per frame; debounces `go` into start and flap requests.

---
 rtl/game_control.sv | 147 ++++++++++++++
 tb/tb_game_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// game_control: frame sequencer for the flappy-bird datapath.
//   Each frame: draw bird, top wall, bottom wall; hold FRAME_CYCLES; erase all
//   three; one-cycle UPDATE; one-cycle CHECK of the collision flag.
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-low
//   go             key level; rising edge starts a game or requests a flap
//   finished_draw  rectangle drawer reports the current rectangle complete
//   collision      collision checker result, sampled in CHECK
//   cur_state      registered state code to the datapath
//   update_en      one-cycle pulse in UPDATE
//   flap           upward impulse, only valid with update_en
//   game_over      high in GAME_OVER
//   score          frames survived, saturating at 255
//   draw_err       sticky draw/erase timeout flag, cleared only by reset
module game_control #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned DRAW_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       finished_draw,
  input  logic       collision,
  output logic [3:0] cur_state,
  output logic       update_en,
  output logic       flap,
  output logic       game_over,
  output logic [7:0] score,
  output logic       draw_err
);

  localparam int unsigned MAX_CNT = (FRAME_CYCLES > DRAW_TIMEOUT) ? FRAME_CYCLES : DRAW_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [3:0] {
    S_DRAW_BIRD      = 4'd0,
    S_DRAW_WALL_TOP  = 4'd1,
    S_DRAW_WALL_BOT  = 4'd2,
    S_ERASE_BIRD     = 4'd3,
    S_ERASE_WALL_TOP = 4'd4,
    S_ERASE_WALL_BOT = 4'd5,
    S_WAIT_FRAME     = 4'd6,
    S_UPDATE         = 4'd7,
    S_CHECK          = 4'd8,
    S_IDLE           = 4'd9,
    S_GAME_OVER      = 4'd10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               latch_q, latch_d;
  logic               go_prev_q, go_prev_d;
  logic [7:0]         score_q, score_d;
  logic               err_q, err_d;

  logic go_rise;
  logic is_draw;
  logic draw_done;
  logic draw_to;
  logic adv;

  always_comb begin
    go_rise   = go & ~go_prev_q;
    is_draw   = (state_q <= S_ERASE_WALL_BOT);
    // Entry cycle (cnt_q == 0) ignores a stale done from the previous rectangle.
    draw_done = (cnt_q != '0) & finished_draw;
    draw_to   = (cnt_q == CNT_W'(DRAW_TIMEOUT - 1));
    adv       = draw_done | draw_to;

    state_d   = state_q;
    latch_d   = latch_q;
    score_d   = score_q;
    err_d     = err_q;
    go_prev_d = go;

    case (state_q)
      S_DRAW_BIRD:      if (adv) state_d = S_DRAW_WALL_TOP;
      S_DRAW_WALL_TOP:  if (adv) state_d = S_DRAW_WALL_BOT;
      S_DRAW_WALL_BOT:  if (adv) state_d = S_WAIT_FRAME;
      S_ERASE_BIRD:     if (adv) state_d = S_ERASE_WALL_TOP;
      S_ERASE_WALL_TOP: if (adv) state_d = S_ERASE_WALL_BOT;
      S_ERASE_WALL_BOT: begin
        if (adv) begin
          state_d = S_UPDATE;
          // Score is bumped on entry so it is already visible during UPDATE.
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end
      end
      S_WAIT_FRAME: if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) state_d = S_ERASE_BIRD;
      S_UPDATE: begin
        state_d = S_CHECK;
        latch_d = 1'b0;
      end
      S_CHECK: state_d = collision ? S_GAME_OVER : S_DRAW_BIRD;
      S_IDLE: begin
        if (go_rise) begin
          state_d = S_DRAW_BIRD;
          score_d = '0;
          latch_d = 1'b0;
        end
      end
      S_GAME_OVER: if (go_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Presses during drawing, waiting or checking are remembered for the next UPDATE.
    if (go_rise && (is_draw || state_q == S_WAIT_FRAME || state_q == S_CHECK))
      latch_d = 1'b1;

    if (is_draw && draw_to && !draw_done) err_d = 1'b1;

    // Counter runs only in draw/erase and WAIT_FRAME; bounded by the exit compares.
    if (state_d != state_q || !(is_draw || state_q == S_WAIT_FRAME))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      latch_q   <= 1'b0;
      go_prev_q <= 1'b0;
      score_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      go_prev_q <= go_prev_d;
      score_q   <= score_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    cur_state = state_q;
    update_en = (state_q == S_UPDATE);
    flap      = (state_q == S_UPDATE) & (latch_q | go_rise);
    game_over = (state_q == S_GAME_OVER);
    score     = score_q;
    draw_err  = err_q;
  end

endmodule

// File: tb/tb_game_control.sv
// Testbench for game_control: directed sequence of frames with randomized
// drawer delays, key presses and collision noise, checked each cycle against
// a frame-schedule model (phase list with computed durations).
module tb_game_control;

  localparam int FC = 10;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       finished_draw;
  logic       collision;
  logic [3:0] cur_state;
  logic       update_en;
  logic       flap;
  logic       game_over;
  logic [7:0] score;
  logic       draw_err;

  game_control #(.FRAME_CYCLES(FC), .DRAW_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .finished_draw (finished_draw),
    .collision     (collision),
    .cur_state     (cur_state),
    .update_en     (update_en),
    .flap          (flap),
    .game_over     (game_over),
    .score         (score),
    .draw_err      (draw_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   exp_score;
  logic exp_err;
  logic exp_latch;
  logic gprev;
  int   dly [6];   // drawer delay per draw/erase state (done held from that cycle on)

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input int st, input logic rise);
    chk("cur_state", 8'(cur_state), 8'(st));
    chk("update_en", 8'(update_en), 8'(st == 7));
    chk("flap",      8'(flap),      8'((st == 7) && (exp_latch || rise)));
    chk("game_over", 8'(game_over), 8'(st == 10));
    chk("score",     score,         8'(exp_score));
    chk("draw_err",  8'(draw_err),  8'(exp_err));
  endtask

  // One cycle in IDLE (9) or GAME_OVER (10) with the given key level.
  task automatic idle_cyc(input logic g, input int st);
    logic rise;
    @(negedge clk);
    go            = g;
    finished_draw = 1'($urandom_range(0, 1));
    collision     = 1'($urandom_range(0, 1));
    #1;
    rise = g & ~gprev;
    chk_all(st, rise);
    if (st == 9 && rise) begin
      exp_score = 0;
      exp_latch = 1'b0;
    end
    gprev = g;
  endtask

  // One full frame starting in DRAW_BIRD.
  // mode: 0 no presses, 1 random presses, 2 two presses in WAIT_FRAME, 3 press in UPDATE.
  // abort_st: stop after the second cycle of that state (-1: never).
  task automatic run_frame(input logic col, input int mode, input int abort_st);
    int   seq [9] = '{0, 1, 2, 6, 3, 4, 5, 7, 8};
    int   st, dur, dd;
    logic tmo, g, rise;
    for (int p = 0; p < 9; p++) begin
      st  = seq[p];
      tmo = 1'b0;
      if (st <= 5) begin
        dd  = (dly[st] < 1 ? 1 : dly[st]) + 1;
        tmo = (dd > TO);
        dur = tmo ? TO : dd;
      end else if (st == 6) begin
        dur = FC;
      end else begin
        dur = 1;
      end
      if (st == 7 && exp_score != 255) exp_score++;
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        case (mode)
          1:       g = ($urandom_range(0, 3) == 0);
          2:       g = (st == 6) && (c == 2 || c == 5);
          3:       g = (st == 7);
          default: g = 1'b0;
        endcase
        go            = g;
        finished_draw = (st <= 5) ? (c >= dly[st]) : 1'($urandom_range(0, 1));
        collision     = (st == 8) ? col : 1'($urandom_range(0, 1));
        #1;
        rise = g & ~gprev;
        chk_all(st, rise);
        if (st == 7) exp_latch = 1'b0;
        else if (rise) exp_latch = 1'b1;
        gprev = g;
        if (st == abort_st && c == 1) return;
      end
      if (tmo) exp_err = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; finished_draw = 1'b0; collision = 1'b0;
    exp_score = 0; exp_err = 1'b0; exp_latch = 1'b0; gprev = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) idle_cyc(1'b0, 9);

    // Start; nominal drawer (done 5 cycles after entry)
    idle_cyc(1'b1, 9);
    for (int k = 0; k < 6; k++) dly[k] = 5;
    run_frame(1'b0, 0, -1);

    // Drawer done held high: two cycles per draw/erase state
    for (int k = 0; k < 6; k++) dly[k] = 0;
    run_frame(1'b0, 0, -1);

    // Two presses in WAIT_FRAME collapse to one flap; then a press in UPDATE itself
    for (int k = 0; k < 6; k++) dly[k] = 3;
    run_frame(1'b0, 2, -1);
    run_frame(1'b0, 3, -1);
    run_frame(1'b0, 0, -1);

    // Randomized frames (drawer delays occasionally past the timeout)
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 6; k++) dly[k] = $urandom_range(0, 22);
      run_frame(1'b0, 1, -1);
    end

    // Collision ends the game
    for (int k = 0; k < 6; k++) dly[k] = $urandom_range(0, 8);
    run_frame(1'b1, 1, -1);
    for (int i = 0; i < 4; i++) idle_cyc(1'b0, 10);
    idle_cyc(1'b1, 10);
    for (int i = 0; i < 3; i++) idle_cyc(1'b0, 9);
    idle_cyc(1'b1, 9);

    // Drawer never finishes: every draw/erase times out; score saturates
    for (int k = 0; k < 6; k++) dly[k] = 1000;
    for (int f = 0; f < 256; f++) run_frame(1'b0, 0, -1);

    // Reset in ERASE_WALL_TOP
    run_frame(1'b0, 0, 4);
    @(negedge clk);
    reset = 1'b0;
    go    = 1'b0;
    exp_score = 0; exp_err = 1'b0; exp_latch = 1'b0; gprev = 1'b0;
    @(negedge clk);
    #1;
    chk_all(9, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle_cyc(1'b0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
